// File: rtl/apb_multi_timer_if.sv
// APB slave bus bundle for apb_multi_timer: zero-wait-state access with error response.
interface apb_multi_timer_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  sel;
  logic                  enable;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  slverr;

  modport master (
    output sel, enable, write, addr, wdata,
    input  rdata, ready, slverr
  );

  modport slave (
    input  sel, enable, write, addr, wdata,
    output rdata, ready, slverr
  );
endinterface

// File: rtl/apb_multi_timer.sv
// NUM_CH up-counter timers sharing one prescaler and one APB slave port.
// Per channel: one-shot/periodic modes, sticky W1C DONE flag, maskable interrupt.
module apb_multi_timer #(
  parameter int BASE_ADDR  = 0,
  parameter int NUM_CH     = 4,
  parameter int TIMER_BITS = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  apb_multi_timer_if.slave   bus,
  output logic               irq
);

  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] PRES_OFF = (ADDR_WIDTH+1)'(4 * NUM_CH);

  logic [TIMER_BITS-1:0] load_q  [NUM_CH];
  logic [TIMER_BITS-1:0] count_q [NUM_CH];
  logic [NUM_CH-1:0]     en_q, mode_q, ie_q, done_q;
  logic [TIMER_BITS-1:0] prescale_q, pcnt_q;

  logic [ADDR_WIDTH:0]   off;
  logic                  below, in_ch, is_pres, access, wr, tick, pres_wr;
  logic [ADDR_WIDTH-3:0] ch_off;
  logic [1:0]            reg_sel;
  logic [NUM_CH-1:0]     hit, ctrl_wr, load_wr, stat_wr, done_set;

  // Offset is computed one bit wider so addresses below BASE_ADDR show up as a borrow.
  assign off     = {1'b0, bus.addr} - BASE_EXT;
  assign below   = off[ADDR_WIDTH];
  assign in_ch   = !below && (off < PRES_OFF);
  assign is_pres = !below && (off == PRES_OFF);
  assign ch_off  = off[ADDR_WIDTH-1:2];
  assign reg_sel = off[1:0];

  assign access    = bus.sel & bus.enable & reset;
  assign bus.ready = access;
  assign wr        = access & bus.write;
  assign pres_wr   = wr & is_pres;
  assign tick      = (pcnt_q == prescale_q);

  always_comb begin
    hit      = '0;
    ctrl_wr  = '0;
    load_wr  = '0;
    stat_wr  = '0;
    done_set = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      hit[c]      = in_ch && (ch_off == (ADDR_WIDTH-2)'(c));
      ctrl_wr[c]  = wr && hit[c] && (reg_sel == 2'd0);
      load_wr[c]  = wr && hit[c] && (reg_sel == 2'd1);
      stat_wr[c]  = wr && hit[c] && (reg_sel == 2'd3) && bus.wdata[0];
      done_set[c] = tick && en_q[c] && (count_q[c] == load_q[c]);
    end
  end

  always_comb begin
    bus.rdata  = '0;
    bus.slverr = 1'b0;
    if (access) begin
      if (in_ch) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (hit[c]) begin
            case (reg_sel)
              2'd0: bus.rdata = TIMER_BITS'({ie_q[c], mode_q[c], en_q[c]});
              2'd1: bus.rdata = load_q[c];
              2'd2: begin
                bus.rdata  = count_q[c];
                bus.slverr = bus.write;
              end
              default: bus.rdata = TIMER_BITS'(done_q[c]);
            endcase
          end
        end
      end else if (is_pres) begin
        bus.rdata = prescale_q;
      end else begin
        bus.slverr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
      irq        <= 1'b0;
      en_q       <= '0;
      mode_q     <= '0;
      ie_q       <= '0;
      done_q     <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        load_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else begin
      irq <= |(done_q & ie_q);

      if (pres_wr) begin
        prescale_q <= bus.wdata;
        pcnt_q     <= '0;
      end else if (tick) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + TIMER_BITS'(1);
      end

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (tick && en_q[c]) begin
          if (count_q[c] == load_q[c]) begin
            count_q[c] <= '0;
            if (!mode_q[c]) en_q[c] <= 1'b0;
          end else begin
            count_q[c] <= count_q[c] + TIMER_BITS'(1);
          end
        end
        // Placed after the hardware update so a software CTRL write overrides a one-shot EN clear.
        if (ctrl_wr[c]) begin
          en_q[c]   <= bus.wdata[0];
          mode_q[c] <= bus.wdata[1];
          ie_q[c]   <= bus.wdata[2];
          if (bus.wdata[0] && !en_q[c]) count_q[c] <= '0;
        end
        if (load_wr[c]) load_q[c] <= bus.wdata;
        if (done_set[c])     done_q[c] <= 1'b1;
        else if (stat_wr[c]) done_q[c] <= 1'b0;
      end
    end
  end

endmodule
